// File: rtl/fifo_pop_arbiter.sv
// Round-robin pop from NUM_IN input FIFOs; each word is routed to one of NUM_OUT output
// FIFOs by its destination field, two cycles after the pop.
module fifo_pop_arbiter #(
   parameter int WIDTH     = 12,
   parameter int NUM_IN    = 4,
   parameter int NUM_OUT   = 4,
   parameter int DEST_BITS = 2,
   parameter int DEST_LSB  = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN-1:0]       fifo_empty,
   input  logic [NUM_IN*WIDTH-1:0] fifo_data,
   output logic [NUM_IN-1:0]       pop,
   input  logic [NUM_OUT-1:0]      out_alm_full,
   output logic [NUM_OUT-1:0]      push_out,
   output logic [WIDTH-1:0]        data_out,
   output logic                    idle
);
   localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   logic [IDX_W-1:0]   last_gnt_reg;
   logic [IDX_W-1:0]   sel1_reg;
   logic               v1_reg;
   logic               v2_reg;
   logic [NUM_OUT-1:0] push_reg;
   logic [WIDTH-1:0]   data_reg;

   logic [WIDTH-1:0]   in_word [NUM_IN];
   logic [IDX_W-1:0]   cand_idx [NUM_IN];
   logic               stall;
   logic               gnt_valid;
   logic               grant;
   logic [IDX_W-1:0]   gnt_idx;
   logic [WIDTH-1:0]   rd_word;
   logic [NUM_OUT-1:0] dest_onehot;

   // cand_idx[k] is the (k+1)-th input after the last grant, wrapping modulo NUM_IN.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_in
         assign in_word[gi]  = fifo_data[gi*WIDTH +: WIDTH];
         assign cand_idx[gi] = IDX_W'((int'(last_gnt_reg) + gi + 1) % NUM_IN);
      end
   endgenerate

   // Scan farthest candidate first so the nearest eligible one is the last to win.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = last_gnt_reg;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         if (!fifo_empty[cand_idx[k]]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand_idx[k];
         end
      end
   end

   // Destination is unknown before the read, so any almost-full output blocks all pops.
   assign stall = |out_alm_full;
   assign grant = gnt_valid && !stall && !reset;

   always_comb begin
      pop = '0;
      if (grant) begin
         pop[gnt_idx] = 1'b1;
      end
   end

   assign rd_word     = in_word[sel1_reg];
   assign dest_onehot = NUM_OUT'(1) << rd_word[DEST_LSB +: DEST_BITS];

   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt_reg <= IDX_W'(NUM_IN - 1);
         sel1_reg     <= '0;
         v1_reg       <= 1'b0;
         v2_reg       <= 1'b0;
         push_reg     <= '0;
         data_reg     <= '0;
      end else begin
         v1_reg <= grant;
         if (grant) begin
            last_gnt_reg <= gnt_idx;
            sel1_reg     <= gnt_idx;
         end
         v2_reg   <= v1_reg;
         push_reg <= v1_reg ? dest_onehot : '0;
         if (v1_reg) begin
            data_reg <= rd_word;
         end
      end
   end

   assign push_out = push_reg;
   assign data_out = data_reg;
   assign idle     = reset || ((pop == '0) && !v1_reg && !v2_reg);

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Bench for fifo_pop_arbiter: input FIFOs modelled as queues, expected pops and pushes
// derived from the round-robin rule and a due-cycle list of popped words.
module tb_fifo_pop_arbiter;
   localparam int WIDTH   = 12;
   localparam int NUM_IN  = 4;
   localparam int NUM_OUT = 4;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [NUM_IN-1:0]       fifo_empty = '1;
   logic [NUM_IN*WIDTH-1:0] fifo_data = '0;
   logic [NUM_IN-1:0]       pop;
   logic [NUM_OUT-1:0]      out_alm_full = '0;
   logic [NUM_OUT-1:0]      push_out;
   logic [WIDTH-1:0]        data_out;
   logic                    idle;

   always #5 clk = ~clk;

   fifo_pop_arbiter #(
      .WIDTH(WIDTH), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DEST_BITS(2), .DEST_LSB(10)
   ) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .pop(pop), .out_alm_full(out_alm_full), .push_out(push_out),
      .data_out(data_out), .idle(idle)
   );

   typedef logic [WIDTH-1:0] word_q_t [$];
   typedef struct {
      int               due;
      logic [WIDTH-1:0] word;
   } flight_t;

   word_q_t          in_q [NUM_IN];
   logic [WIDTH-1:0] rd_data [NUM_IN];
   flight_t          flight_q [$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int               exp_last = NUM_IN - 1;
   int               exp_idx;
   logic [WIDTH-1:0] exp_data = '0;
   logic [3:0]       exp_pop, exp_push, obs_pop, obs_push;
   logic [11:0]      obs_data;
   logic             exp_idle, obs_idle;
   logic [20:0]      obs_v, exp_v;

   // First non-empty input after 'last', wrapping; -1 when all are empty.
   function automatic int ref_pick(input logic [3:0] empty, input int last);
      for (int k = 1; k <= NUM_IN; k++) begin
         if (!empty[(last + k) % NUM_IN]) return (last + k) % NUM_IN;
      end
      return -1;
   endfunction

   // One clock: present FIFO state, sample DUT and model at negedge, then advance both.
   task automatic run_cycle();
      flight_t f;
      for (int i = 0; i < NUM_IN; i++) begin
         fifo_empty[i] = (in_q[i].size() == 0);
         fifo_data[i*WIDTH +: WIDTH] = rd_data[i];
      end
      @(negedge clk);
      obs_pop  = pop;
      obs_push = push_out;
      obs_data = data_out;
      obs_idle = idle;
      while (flight_q.size() > 0 && flight_q[0].due < cyc) void'(flight_q.pop_front());
      exp_idx  = (reset || (out_alm_full != 0)) ? -1 : ref_pick(fifo_empty, exp_last);
      exp_pop  = (exp_idx < 0) ? 4'b0000 : (4'b0001 << exp_idx);
      exp_push = 4'b0000;
      if (flight_q.size() > 0 && flight_q[0].due == cyc) begin
         exp_push = 4'b0001 << flight_q[0].word[11:10];
         exp_data = flight_q[0].word;
      end
      exp_idle = reset || (exp_pop == 0 && flight_q.size() == 0);
      obs_v = {obs_pop, obs_push, obs_data, obs_idle};
      exp_v = {exp_pop, exp_push, exp_data, exp_idle};
      @(posedge clk);
      #1;
      if (reset) begin
         flight_q.delete();
         exp_last = NUM_IN - 1;
         exp_data = '0;
      end else if (exp_idx >= 0) begin
         f.due  = cyc + 2;
         f.word = in_q[exp_idx][0];
         flight_q.push_back(f);
         exp_last = exp_idx;
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (obs_pop[i] && in_q[i].size() > 0) rd_data[i] = in_q[i].pop_front();
      end
      cyc++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      run_cycle();
      run_cycle();
      n_tests++;
      if (obs_v !== 21'h1) begin
         n_fail++;
         $display("FAIL reset_state cyc=%0d got pop/push/data/idle=%b/%b/%h/%b want 0000/0000/000/1",
                  cyc, obs_pop, obs_push, obs_data, obs_idle);
      end
      reset = 1'b0;
      for (int t = 0; t < 10; t++) begin
         run_cycle();
         n_tests++;
         if (obs_v !== exp_v || obs_v !== 21'h1) begin
            n_fail++;
            $display("FAIL reset_empty cyc=%0d got pop/push/data/idle=%b/%b/%h/%b want 0000/0000/000/1",
                     cyc, obs_pop, obs_push, obs_data, obs_idle);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0]  rr_pop  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0]  rr_push [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      logic [11:0] rr_data [4] = '{12'h000, 12'h500, 12'hA00, 12'hF00};
      for (int i = 0; i < NUM_IN; i++) begin
         for (int n = 0; n < 2; n++) in_q[i].push_back(12'((i << 8) | (i << 10)));
      end
      for (int t = 0; t < 11; t++) begin
         run_cycle();
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL round_robin cyc=%0d got pop/push/data/idle=%b/%b/%h/%b want %b/%b/%h/%b",
                     cyc, obs_pop, obs_push, obs_data, obs_idle, exp_pop, exp_push, exp_data, exp_idle);
         end
         if (t < 5) begin
            n_tests++;
            if (obs_pop !== rr_pop[t]) begin
               n_fail++;
               $display("FAIL rr_pop_seq step=%0d got pop=%b want %b", t, obs_pop, rr_pop[t]);
            end
         end
         if (t >= 2 && t < 6) begin
            n_tests++;
            if (obs_push !== rr_push[t-2] || obs_data !== rr_data[t-2]) begin
               n_fail++;
               $display("FAIL rr_push_seq step=%0d got push=%b data=%h want %b %h",
                        t, obs_push, obs_data, rr_push[t-2], rr_data[t-2]);
            end
         end
      end
   endtask

   task automatic test_single_input();
      for (int n = 0; n < 5; n++) in_q[2].push_back(12'hC05);
      for (int t = 0; t < 9; t++) begin
         run_cycle();
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL single_model cyc=%0d got pop/push/data/idle=%b/%b/%h/%b want %b/%b/%h/%b",
                     cyc, obs_pop, obs_push, obs_data, obs_idle, exp_pop, exp_push, exp_data, exp_idle);
         end
         if (t >= 2 && t < 7) begin
            n_tests++;
            if (obs_push !== 4'b1000 || obs_data !== 12'hC05) begin
               n_fail++;
               $display("FAIL single_push step=%0d got push=%b data=%h want 1000 c05", t, obs_push, obs_data);
            end
         end
      end
   endtask

   task automatic test_stall();
      int stall_pushes = 0;
      for (int i = 0; i < NUM_IN; i++) begin
         for (int n = 0; n < 10; n++) in_q[i].push_back(12'($urandom_range(4095)));
      end
      for (int t = 0; t < 49; t++) begin
         out_alm_full = (t >= 4 && t < 9) ? 4'b0010 : 4'b0000;
         run_cycle();
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL stall_model cyc=%0d got pop/push/data/idle=%b/%b/%h/%b want %b/%b/%h/%b",
                     cyc, obs_pop, obs_push, obs_data, obs_idle, exp_pop, exp_push, exp_data, exp_idle);
         end
         if (t >= 4 && t < 9) begin
            if (obs_push != 0) stall_pushes++;
            n_tests++;
            if (obs_pop !== 4'b0000) begin
               n_fail++;
               $display("FAIL stall_pop step=%0d got pop=%b want 0000", t, obs_pop);
            end
         end
      end
      n_tests++;
      if (stall_pushes != 2) begin
         n_fail++;
         $display("FAIL stall_inflight got %0d pushes during stall want 2", stall_pushes);
      end
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < NUM_IN; i++) begin
         for (int n = 0; n < 3; n++) in_q[i].push_back(12'($urandom_range(4095)));
      end
      for (int t = 0; t < 18; t++) begin
         reset = (t == 1);
         run_cycle();
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL midreset_model cyc=%0d got pop/push/data/idle=%b/%b/%h/%b want %b/%b/%h/%b",
                     cyc, obs_pop, obs_push, obs_data, obs_idle, exp_pop, exp_push, exp_data, exp_idle);
         end
         if (t == 2 || t == 3) begin
            n_tests++;
            if (obs_push !== 4'b0000 || obs_data !== 12'h000) begin
               n_fail++;
               $display("FAIL midreset_drop step=%0d got push=%b data=%h want 0000 000", t, obs_push, obs_data);
            end
         end
         if (t == 2) begin
            n_tests++;
            if (obs_pop !== 4'b0001) begin
               n_fail++;
               $display("FAIL midreset_first_gnt got pop=%b want 0001", obs_pop);
            end
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_alternate();
      logic [3:0] prev_pop = 4'b0000;
      for (int n = 0; n < 7; n++) in_q[3].push_back(12'($urandom_range(4095)));
      for (int t = 0; t < 16; t++) begin
         if (t == 3) begin
            for (int n = 0; n < 5; n++) in_q[0].push_back(12'($urandom_range(4095)));
         end
         run_cycle();
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL alternate_model cyc=%0d got pop/push/data/idle=%b/%b/%h/%b want %b/%b/%h/%b",
                     cyc, obs_pop, obs_push, obs_data, obs_idle, exp_pop, exp_push, exp_data, exp_idle);
         end
         if (t >= 4 && fifo_empty[0] == 1'b0 && fifo_empty[3] == 1'b0) begin
            n_tests++;
            if (obs_pop === prev_pop || obs_pop === 4'b0000) begin
               n_fail++;
               $display("FAIL alternate_fair step=%0d got pop=%b after %b", t, obs_pop, prev_pop);
            end
         end
         prev_pop = obs_pop;
      end
   endtask

   task automatic test_random();
      int idx;
      for (int t = 0; t < 440; t++) begin
         if (t < 400) begin
            if ($urandom_range(9) < 4) begin
               idx = int'($urandom_range(NUM_IN - 1));
               if (in_q[idx].size() < 8) in_q[idx].push_back(12'($urandom_range(4095)));
            end
            out_alm_full = ($urandom_range(4) == 0) ? 4'($urandom_range(15)) : 4'b0000;
            reset = ($urandom_range(63) == 0);
         end else begin
            out_alm_full = 4'b0000;
            reset = 1'b0;
         end
         run_cycle();
         n_tests++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL random cyc=%0d got pop/push/data/idle=%b/%b/%h/%b want %b/%b/%h/%b",
                     cyc, obs_pop, obs_push, obs_data, obs_idle, exp_pop, exp_push, exp_data, exp_idle);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NUM_IN; i++) rd_data[i] = '0;
      test_reset();
      test_round_robin();
      test_single_input();
      test_stall();
      test_reset_midflight();
      test_alternate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
